// File: rtl/mdp_pkg.sv
// Shared definitions for the multicycle datapath: phase codes, ALU opcodes,
// flag bit positions and the branch condition helper.
package mdp_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OPX_W   = 11;
  localparam int unsigned FLAG_W  = 4;

  // Phase FSM state codes; also driven out on the phase port.
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } phase_t;

  // ALU operation encodings.
  localparam logic [2:0] ALU_PASSB = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_XOR   = 3'b101;
  localparam logic [2:0] ALU_SHL   = 3'b110;
  localparam logic [2:0] ALU_SHR   = 3'b111;

  // Bit positions inside the {Z,N,V,C} flag vector.
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 0;

  // Signed greater-than after a compare: N == V and result non-zero.
  function automatic logic branch_gt(input logic [FLAG_W-1:0] f);
    return (f[FLAG_N] ~^ f[FLAG_V]) & ~f[FLAG_Z];
  endfunction

endpackage

// File: rtl/mdp_alu.sv
// Combinational ALU for the multicycle datapath.
// Ports:
//   op       - ALU operation (mdp_pkg ALU_* codes)
//   a, b     - operands, DATA_W bits
//   result_c - operation result
//   flags_c  - {Z,N,V,C}; V and C only meaningful for add/sub, else 0
module mdp_alu
  import mdp_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result_c,
  output logic [FLAG_W-1:0] flags_c
);

  localparam int unsigned MSB = DATA_W - 1;

  logic [DATA_W:0] wide;
  logic            carry;
  logic            ovf;

  // Result plus carry/overflow; carry on subtract means "no borrow".
  always_comb begin
    wide     = '0;
    carry    = 1'b0;
    ovf      = 1'b0;
    result_c = '0;
    case (op)
      ALU_PASSB: result_c = b;
      ALU_ADD: begin
        wide     = {1'b0, a} + {1'b0, b};
        result_c = wide[MSB:0];
        carry    = wide[DATA_W];
        ovf      = (a[MSB] == b[MSB]) && (wide[MSB] != a[MSB]);
      end
      ALU_SUB: begin
        wide     = {1'b0, a} - {1'b0, b};
        result_c = wide[MSB:0];
        carry    = ~wide[DATA_W];
        ovf      = (a[MSB] != b[MSB]) && (wide[MSB] != a[MSB]);
      end
      ALU_AND: result_c = a & b;
      ALU_OR:  result_c = a | b;
      ALU_XOR: result_c = a ^ b;
      ALU_SHL: result_c = a << b[4:0];
      ALU_SHR: result_c = a >> b[4:0];
      default: result_c = '0;
    endcase
  end

  // Flag vector assembly.
  always_comb begin
    flags_c         = '0;
    flags_c[FLAG_Z] = (result_c == '0);
    flags_c[FLAG_N] = result_c[MSB];
    flags_c[FLAG_V] = ovf;
    flags_c[FLAG_C] = carry;
  end

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle datapath: FETCH/DECODE/EXEC/MEM/WB sequenced by an internal
// phase FSM on a single clock. Control comes from an external decoder fed
// by instx_op; data memory is behind a req/ack handshake that stalls MEM.
// Optional feature macro: MDP_SHIFT_EN (adds alu_shift, immediate B operand).
// Ports:
//   Phi        - clock, rising edge
//   RST        - asynchronous active-low reset
//   imem_addr  - PC, instruction memory address
//   imem_data  - instruction word
//   instx_op   - IR[31:21] to the control decoder
//   phase      - current FSM state code
//   alu_op, swe, mem_en, rnw, r2loc, wd_mux, pcc, bsc, bgr - decoder controls
//   alu_shift  - B = IR[15:10] immediate (MDP_SHIFT_EN only)
//   dmem_req/we/addr/wdata/rdata/ack - data memory handshake
module multicycle_datapath
  import mdp_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned PC_W    = 7,
  parameter int unsigned NREG    = 32,
  parameter int unsigned DADDR_W = 11
) (
  input  logic                Phi,
  input  logic                RST,
  output logic [PC_W-1:0]     imem_addr,
  input  logic [INSTR_W-1:0]  imem_data,
  output logic [OPX_W-1:0]    instx_op,
  output logic [2:0]          phase,
  input  logic [2:0]          alu_op,
  input  logic                swe,
  input  logic                mem_en,
  input  logic                rnw,
  input  logic                r2loc,
  input  logic                wd_mux,
  input  logic                pcc,
  input  logic                bsc,
  input  logic                bgr,
`ifdef MDP_SHIFT_EN
  input  logic                alu_shift,
`endif
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [DADDR_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]   dmem_wdata,
  input  logic [DATA_W-1:0]   dmem_rdata,
  input  logic                dmem_ack
);

  localparam int unsigned SEL_W = $clog2(NREG);

  phase_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q;
  logic [INSTR_W-1:0]  ir_q;
  logic [DATA_W-1:0]   a_q, b_q, aluout_q, ldr_q;
  logic [FLAG_W-1:0]   flags_q;
  logic [DATA_W-1:0]   rf [NREG];
  logic                req_q, we_q;
  logic                req_d, we_d;

  logic [SEL_W-1:0]    rn_sel, rm_sel, rd_sel;
  logic [DATA_W-1:0]   ra_c, rb_c, b_in_c, wd_c;
  logic [DATA_W-1:0]   alu_res_c;
  logic [FLAG_W-1:0]   alu_flags_c;
  logic                rf_we_c;
  logic                taken_c;
  logic [PC_W-1:0]     pc_next_c;

  assign imem_addr  = pc_q;
  assign instx_op   = ir_q[31:21];
  assign phase      = state_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = a_q[DADDR_W-1:0];
  assign dmem_wdata = b_q;

  // IR bits not consumed by every build, kept visible to avoid dangling nets.
  logic unused_bits;
  assign unused_bits = ^{ir_q[15:12], flags_q[FLAG_C]};

  mdp_alu #(.DATA_W(DATA_W)) u_alu (
    .op       (alu_op),
    .a        (a_q),
    .b        (b_q),
    .result_c (alu_res_c),
    .flags_c  (alu_flags_c)
  );

  // Register file read ports; the top register is hard-wired to zero.
  always_comb begin
    rn_sel = ir_q[5 +: SEL_W];
    rm_sel = r2loc ? ir_q[0 +: SEL_W] : ir_q[16 +: SEL_W];
    rd_sel = ir_q[0 +: SEL_W];
    ra_c   = (32'(rn_sel) >= NREG - 1) ? '0 : rf[rn_sel];
    rb_c   = (32'(rm_sel) >= NREG - 1) ? '0 : rf[rm_sel];
`ifdef MDP_SHIFT_EN
    b_in_c = alu_shift ? DATA_W'(ir_q[15:10]) : rb_c;
`else
    b_in_c = rb_c;
`endif
  end

  // Write-back data, write enable and next PC.
  always_comb begin
    wd_c      = wd_mux ? ldr_q : aluout_q;
    rf_we_c   = swe && (32'(rd_sel) < NREG - 1);
    taken_c   = bgr & branch_gt(flags_q);
    pc_next_c = pc_q + PC_W'(1);
    if (pcc) begin
      pc_next_c = bsc ? a_q[PC_W-1:0] : ir_q[PC_W-1:0];
    end else if (taken_c) begin
      pc_next_c = ir_q[5 +: PC_W];
    end
  end

  // Phase FSM next state and registered handshake outputs.
  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    we_d    = 1'b0;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE:  state_d = EXEC;
      EXEC:    state_d = mem_en ? MEM : WB;
      MEM:     state_d = dmem_ack ? WB : MEM;
      WB:      state_d = FETCH;
      default: state_d = FETCH;
    endcase
    if (state_d == MEM) begin
      req_d = 1'b1;
      we_d  = ~rnw;
    end
  end

  // State register.
  always_ff @(posedge Phi or negedge RST) begin
    if (!RST) begin
      state_q <= FETCH;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
    end
  end

  // Datapath hold registers, PC and register file, updated per phase.
  always_ff @(posedge Phi or negedge RST) begin
    if (!RST) begin
      pc_q     <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      ldr_q    <= '0;
      flags_q  <= '0;
      for (int unsigned i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else begin
      case (state_q)
        FETCH: ir_q <= imem_data;
        DECODE: begin
          a_q <= ra_c;
          b_q <= b_in_c;
        end
        EXEC: begin
          aluout_q <= alu_res_c;
          flags_q  <= alu_flags_c;
        end
        MEM: begin
          if (dmem_ack && rnw) begin
            ldr_q <= dmem_rdata;
          end
        end
        WB: begin
          pc_q <= pc_next_c;
          if (rf_we_c) begin
            rf[rd_sel] <= wd_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Table-driven bench for multicycle_datapath: the bench acts as control
// decoder, instruction memory and data memory, and observes register
// contents through store instructions (R2 appears on dmem_wdata).
module tb_multicycle_datapath;
  import mdp_pkg::*;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned PC_W    = 7;
  localparam int unsigned DADDR_W = 11;

  logic                Phi = 1'b0;
  logic                RST;
  logic [PC_W-1:0]     imem_addr;
  logic [31:0]         imem_data;
  logic [10:0]         instx_op;
  logic [2:0]          phase;
  logic [2:0]          alu_op;
  logic                swe, mem_en, rnw, r2loc, wd_mux, pcc, bsc, bgr;
  logic                alu_shift;
  logic                dmem_req, dmem_we;
  logic [DADDR_W-1:0]  dmem_addr;
  logic [DATA_W-1:0]   dmem_wdata;
  logic [DATA_W-1:0]   dmem_rdata;
  logic                dmem_ack;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Phi = ~Phi;

  multicycle_datapath #(
    .DATA_W(DATA_W), .PC_W(PC_W), .NREG(32), .DADDR_W(DADDR_W)
  ) dut (
    .Phi        (Phi),
    .RST        (RST),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .instx_op   (instx_op),
    .phase      (phase),
    .alu_op     (alu_op),
    .swe        (swe),
    .mem_en     (mem_en),
    .rnw        (rnw),
    .r2loc      (r2loc),
    .wd_mux     (wd_mux),
    .pcc        (pcc),
    .bsc        (bsc),
    .bgr        (bgr),
`ifdef MDP_SHIFT_EN
    .alu_shift  (alu_shift),
`endif
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [2:0]  op;
    logic        swe, mem_en, rnw, r2loc, wd_mux, pcc, bsc, bgr, stray;
    int          ack_delay;
    logic [31:0] rdata;
    int          exp_cycles;
    logic [6:0]  exp_pc;
    logic [10:0] exp_addr;
    logic        exp_we;
    logic        chk_wdata;
    logic [31:0] exp_wdata;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Instruction fields: [31:21] opcode tag, [20:16] Rm, [15:10] imm6, [9:5] Rn, [4:0] Rd.
  function automatic logic [31:0] enc(input int rd, input int rn, input int rm, input int imm6);
    return {11'h3A1, 5'(rm), 6'(imm6), 5'(rn), 5'(rd)};
  endfunction

  function automatic vec_t blank(input string nm, input logic [31:0] ins, input logic [6:0] pc);
    vec_t v;
    v.name = nm; v.instr = ins; v.op = ALU_PASSB;
    v.swe = 0; v.mem_en = 0; v.rnw = 0; v.r2loc = 0; v.wd_mux = 0;
    v.pcc = 0; v.bsc = 0; v.bgr = 0; v.stray = 0;
    v.ack_delay = 0; v.rdata = '0; v.exp_cycles = 4; v.exp_pc = pc;
    v.exp_addr = '0; v.exp_we = 0; v.chk_wdata = 0; v.exp_wdata = '0;
    return v;
  endfunction

  function automatic vec_t v_ld(input string nm, input int rd, input int rn, input logic [31:0] rdata,
                                input int d, input logic [10:0] addr, input logic [6:0] pc);
    vec_t v = blank(nm, enc(rd, rn, 0, 0), pc);
    v.swe = 1; v.mem_en = 1; v.rnw = 1; v.wd_mux = 1;
    v.ack_delay = d; v.rdata = rdata; v.exp_cycles = 5 + d; v.exp_addr = addr;
    return v;
  endfunction

  // Store; with r2loc=1 the stored register is the Rd field.
  function automatic vec_t v_st(input string nm, input int rn, input int rm, input logic r2l,
                                input logic [10:0] addr, input logic [31:0] wdata, input logic [6:0] pc);
    vec_t v = blank(nm, r2l ? enc(rm, rn, 0, 0) : enc(0, rn, rm, 0), pc);
    v.mem_en = 1; v.rnw = 0; v.r2loc = r2l; v.exp_cycles = 5;
    v.exp_addr = addr; v.exp_we = 1; v.chk_wdata = 1; v.exp_wdata = wdata;
    return v;
  endfunction

  function automatic vec_t v_alu(input string nm, input logic [31:0] ins, input logic [2:0] op,
                                 input logic sw, input logic [6:0] pc);
    vec_t v = blank(nm, ins, pc);
    v.op = op; v.swe = sw;
    return v;
  endfunction

  // Drive one instruction from FETCH back to FETCH and check its behaviour.
  task automatic run(input vec_t v);
    int cyc = 0, wait_n = 0, req_n = 0;
    logic [63:0] seq = '0, eseq;
    logic first = 1, stable = 1, we0 = 0;
    logic [DADDR_W-1:0] a0 = '0;
    logic [DATA_W-1:0]  w0 = '0;
    imem_data = v.instr; alu_op = v.op; swe = v.swe; mem_en = v.mem_en; rnw = v.rnw;
    r2loc = v.r2loc; wd_mux = v.wd_mux; pcc = v.pcc; bsc = v.bsc; bgr = v.bgr;
    dmem_rdata = v.rdata;
    do begin
      seq = (seq << 4) | 64'(phase);
      if (dmem_req) req_n++;
      if (phase == 3'd3) begin
        if (first) begin
          a0 = dmem_addr; w0 = dmem_wdata; we0 = dmem_we; first = 0;
        end else if (a0 !== dmem_addr || w0 !== dmem_wdata || we0 !== dmem_we) begin
          stable = 0;
        end
        dmem_ack = (wait_n == v.ack_delay);
        wait_n++;
      end else begin
        dmem_ack = v.stray;
      end
      @(posedge Phi); #1;
      cyc++;
    end while (phase != 3'd0 && cyc < 40);
    dmem_ack = 0;
    eseq = 64'h012;
    if (v.mem_en) for (int i = 0; i <= v.ack_delay; i++) eseq = (eseq << 4) | 64'h3;
    eseq = (eseq << 4) | 64'h4;
    check({v.name, " cycles"}, 64'(cyc), 64'(v.exp_cycles));
    check({v.name, " pc"}, 64'(imem_addr), 64'(v.exp_pc));
    check({v.name, " phase_seq"}, seq, eseq);
    check({v.name, " req_cycles"}, 64'(req_n), v.mem_en ? 64'(v.ack_delay + 1) : 64'd0);
    check({v.name, " req_low_after"}, 64'(dmem_req), 64'd0);
    if (v.mem_en) begin
      check({v.name, " addr"}, 64'(a0), 64'(v.exp_addr));
      check({v.name, " we"}, 64'(we0), 64'(v.exp_we));
      check({v.name, " req_stable"}, 64'(stable), 64'd1);
      if (v.chk_wdata) check({v.name, " wdata"}, 64'(w0), 64'(v.exp_wdata));
    end
  endtask

  initial begin
    vec_t vt[$];
    int guard;

    vt.push_back(v_ld("ld_x1", 1, 31, 32'd5, 0, 11'h0, 7'd1));
    vt.push_back(v_ld("ld_x2", 2, 31, 32'd7, 0, 11'h0, 7'd2));
    vt.push_back(v_alu("add_x3", enc(3, 1, 2, 0), ALU_ADD, 1, 7'd3));
    vt.push_back(v_st("show_x3", 31, 3, 1, 11'h0, 32'd12, 7'd4));
    vt.push_back(v_ld("ld_x4", 4, 31, 32'h10, 0, 11'h0, 7'd5));
    vt.push_back(v_ld("ld_wait3", 5, 4, 32'hDEAD, 3, 11'h10, 7'd6));
    vt.push_back(v_st("show_x5", 31, 5, 1, 11'h0, 32'hDEAD, 7'd7));
    vt.push_back(v_ld("ld_x6", 6, 31, 32'h20, 0, 11'h0, 7'd8));
    vt.push_back(v_ld("ld_x7", 7, 31, 32'h55, 0, 11'h0, 7'd9));
    vt.push_back(v_st("store_20", 6, 7, 0, 11'h20, 32'h55, 7'd10));
    vt.push_back(v_ld("ld_x0_5", 0, 31, 32'd5, 0, 11'h0, 7'd11));
    vt.push_back(v_ld("ld_x9", 9, 31, 32'd3, 0, 11'h0, 7'd12));
    begin
      vec_t b = v_alu("br_5m3_taken", enc(0, 0, 9, 2), ALU_SUB, 0, 7'h40);
      b.bgr = 1; vt.push_back(b);
      vt.push_back(v_ld("ld_x0_3", 0, 31, 32'd3, 0, 11'h0, 7'h41));
      b = v_alu("br_3m3_zero", enc(0, 0, 9, 2), ALU_SUB, 0, 7'h42);
      b.bgr = 1; vt.push_back(b);
      b = v_alu("br_3m5_neg", enc(0, 0, 1, 2), ALU_SUB, 0, 7'h43);
      b.bgr = 1; vt.push_back(b);
      b = v_alu("jump_7f", enc(31, 3, 0, 0), ALU_PASSB, 0, 7'h7F);
      b.pcc = 1; vt.push_back(b);
      vt.push_back(v_alu("wrap_wr_x31", enc(31, 0, 9, 0), ALU_PASSB, 1, 7'h00));
      vt.push_back(v_st("show_x31", 31, 31, 1, 11'h0, 32'd0, 7'd1));
      b = v_alu("jump_reg", enc(0, 9, 0, 0), ALU_PASSB, 0, 7'd3);
      b.pcc = 1; b.bsc = 1; vt.push_back(b);
      b = v_alu("add_nowrite_stray_ack", enc(10, 1, 2, 0), ALU_ADD, 0, 7'd4);
      b.stray = 1; vt.push_back(b);
    end
    vt.push_back(v_st("show_x10", 31, 10, 1, 11'h0, 32'd0, 7'd5));
    vt.push_back(v_alu("shl_x11", enc(11, 1, 9, 0), ALU_SHL, 1, 7'd6));
    vt.push_back(v_st("show_x11", 31, 11, 1, 11'h0, 32'd40, 7'd7));
    vt.push_back(v_alu("shr_x12", enc(12, 5, 9, 0), ALU_SHR, 1, 7'd8));
    vt.push_back(v_st("show_x12", 31, 12, 1, 11'h0, 32'h1BD5, 7'd9));
    vt.push_back(v_alu("or_x13", enc(13, 5, 4, 0), ALU_OR, 1, 7'd10));
    vt.push_back(v_st("show_x13", 31, 13, 1, 11'h0, 32'hDEBD, 7'd11));
    vt.push_back(v_alu("xor_x14", enc(14, 1, 2, 0), ALU_XOR, 1, 7'd12));
    vt.push_back(v_st("show_x14", 31, 14, 1, 11'h0, 32'd2, 7'd13));

    // Reset state.
    RST = 0; imem_data = '0; alu_op = '0; swe = 0; mem_en = 0; rnw = 0; r2loc = 0;
    wd_mux = 0; pcc = 0; bsc = 0; bgr = 0; alu_shift = 0; dmem_rdata = '0; dmem_ack = 0;
    repeat (2) @(posedge Phi);
    #1;
    check("reset phase", 64'(phase), 64'd0);
    check("reset pc", 64'(imem_addr), 64'd0);
    check("reset instx_op", 64'(instx_op), 64'd0);
    check("reset req", 64'(dmem_req), 64'd0);
    check("reset we", 64'(dmem_we), 64'd0);
    @(negedge Phi);
    RST = 1;

    foreach (vt[i]) begin
      run(vt[i]);
      if (i == 2) check("add instx_op", 64'(instx_op), 64'h3A1);
    end

    // Reset asserted in the second MEM cycle of a stalled load.
    imem_data = enc(1, 31, 0, 0); alu_op = ALU_PASSB; swe = 1; mem_en = 1; rnw = 1;
    r2loc = 0; wd_mux = 1; pcc = 0; bsc = 0; bgr = 0; dmem_rdata = 32'hBEEF; dmem_ack = 0;
    guard = 0;
    while (phase != 3'd3 && guard < 10) begin
      @(posedge Phi); #1;
      guard++;
    end
    check("rst_mem reached MEM", 64'(phase), 64'd3);
    @(posedge Phi); #1;
    check("rst_mem req in cycle 2", 64'(dmem_req), 64'd1);
    #2 RST = 0;
    #1;
    check("rst_mem req async drop", 64'(dmem_req), 64'd0);
    check("rst_mem we async drop", 64'(dmem_we), 64'd0);
    check("rst_mem phase", 64'(phase), 64'd0);
    check("rst_mem pc", 64'(imem_addr), 64'd0);
    @(negedge Phi);
    RST = 1;
    check("rst_mem phase after release", 64'(phase), 64'd0);
    run(v_st("rst_mem show_x1", 31, 1, 1, 11'h0, 32'd0, 7'd1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_datapath.md
# multicycle_datapath

Parametrised multicycle datapath: fetch, decode, execute, memory and write-back sequenced by an internal phase FSM on one clock, replacing the six externally generated phase clocks. The external control decoder drives it from `instx_op`. Data memory sits behind a req/ack handshake so variable-latency SRAM stalls the FSM. ALU width, PC width and register count are generic.

## Interface
- `DATA_W`, 32: register, ALU and data-memory word width (≥16).
- `PC_W`, 7: program-counter and instruction-address width (≤16).
- `NREG`, 32: register count; `SEL_W = $clog2(NREG)` (≤5); register `NREG-1` reads zero.
- `DADDR_W`, 11: data-memory address width (≤DATA_W).

Ports:
- `Phi`  in  1  sole clock, rising edge.
- `RST`  in  1  reset, asynchronous, active-low.
- `imem_addr`  out  PC_W  = PC; instruction memory reads combinationally.
- `imem_data`  in  32  instruction word.
- `instx_op`  out  11  IR[31:21] to the control decoder.
- `phase`  out  3  current FSM state code.
- `alu_op`  in  3  ALU operation.
- `swe`  in  1  register write enable in WB.
- `mem_en`  in  1  instruction accesses data memory.
- `rnw`  in  1  1 = load, 0 = store.
- `r2loc`  in  1  read port 2 select: 1 = IR[4:0], 0 = IR[20:16].
- `wd_mux`  in  1  write-back source: 1 = load data, 0 = ALU result.
- `pcc`, `bsc`, `bgr`  in  1 each  next-PC controls (see Operation).
- `alu_shift`  in  1  B = immediate (only with `MDP_SHIFT_EN`).
- `dmem_req`  out  1  access request.
- `dmem_we`  out  1  store strobe, valid with req.
- `dmem_addr`  out  DADDR_W  R1[DADDR_W-1:0].
- `dmem_wdata`  out  DATA_W  R2.
- `dmem_rdata`  in  DATA_W  load data, valid with ack.
- `dmem_ack`  in  1  access complete.

## Operation
- FSM states: FETCH(0), DECODE(1), EXEC(2), MEM(3), WB(4).
- Transitions: FETCH→DECODE→EXEC; EXEC→MEM if `mem_en`, else →WB; MEM→WB on `dmem_ack`, else stay; WB→FETCH.
- FETCH: IR ← `imem_data`.
- DECODE: A ← reg[IR[9:5]]; B ← reg[r2loc ? IR[4:0] : IR[20:16]]. Register selects use the low SEL_W bits.
- EXEC: ALUOUT ← f(A,B); flags {Z,N,V,C} ← result flags. Encodings: 000 passB, 001 add, 010 sub, 011 and, 100 or, 101 xor, 110 shl, 111 shr (shift amount B[4:0]). V and C are meaningful for add/sub only and 0 otherwise; Z and N come from the result.
- MEM: `dmem_req`=1 and `dmem_we`=~rnw, held until ack. On ack with rnw=1, LDR ← `dmem_rdata`.
- WB:
  - If `swe` and Rd=IR[4:0]≠NREG-1: reg[Rd] ← wd_mux ? LDR : ALUOUT.
  - PC ← pcc ? (bsc ? R1[PC_W-1:0] : IR[PC_W-1:0]) : (taken ? IR[5+:PC_W] : PC+1).
  - taken = bgr & (N ~^ V) & ~Z, evaluated on the flags latched in this instruction's EXEC.
- PC arithmetic is modulo 2^PC_W; PC = 2^PC_W−1 increments to 0.
- Control inputs are sampled only in the state that consumes them. They are combinational from the stable IR.

## Timing
- Reset values: state FETCH, PC 0, IR 0, A/B/ALUOUT/LDR 0, flags 0, all registers 0, `dmem_req` 0, `dmem_we` 0, `phase` 0.
- Latency: non-memory instruction 4 cycles; memory instruction 5 + wait cycles, where ack in the first MEM cycle gives 0 wait cycles.
- `dmem_req` rises on the edge entering MEM and falls on the edge leaving MEM. `dmem_addr`, `dmem_wdata` and `dmem_we` are stable for the whole request.
- Reset asserted mid-MEM drops `dmem_req` asynchronously. No register write or PC update is committed.
- `dmem_ack` outside MEM is ignored.

## Configuration
- `MDP_SHIFT_EN` defined: `alu_shift` port present. In DECODE, B ← alu_shift ? zero-extended IR[15:10] : register value.
- `MDP_SHIFT_EN` undefined: port absent; B is always the register value.

## Structure
- `mdp_pkg`: phase enum (FETCH..WB, 3-bit codes), ALU opcode localparams, flag bit indices (Z=3, N=2, V=1, C=0).
- Sub-module `mdp_alu`: combinational, DATA_W-parametrised, result plus flags.
- Top module: phase FSM, PC, IR, register file array, hold registers, handshake.

## Test plan
- Reset, then `alu_op`=001, swe=1, regs X1=5, X2=7, Rd=X3 → X3=12 after 4 cycles; PC 0→1; `phase` sequence 0,1,2,4.
- Load with ack delayed 3 cycles, X1=0x10, rdata=0xDEAD → `dmem_req` high for 4 cycles with addr 0x10; X-dest=0xDEAD; instruction takes 8 cycles.
- Store, X1=0x20, X2=0x55, immediate ack → `dmem_we`=1, wdata=0x55 in a single MEM cycle; no register write.
- Flags from sub 5−3 (N=0, V=0, Z=0), then bgr=1 with IR[11:5]=0x40 → PC=0x40. Repeat with 3−3 → Z=1, PC=PC+1.
- PC=0x7F, no branch → PC=0x00. Write to Rd=31 → reads 0.
- Reset asserted in MEM cycle 2 → `dmem_req` 0 immediately; PC=0; state FETCH after release.
